// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out stream bundle for the 3x3 window generator.
// master = pixel source and window consumer, slave = the generator.
interface window_gen_3x3_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    in_valid;
  logic [DATA_WIDTH-1:0]   in_pixel;
  logic                    out_valid;
  logic [9*DATA_WIDTH-1:0] out_win;
  logic                    frame_done;

  modport master (
    output in_valid, in_pixel,
    input  out_valid, out_win, frame_done
  );

  modport slave (
    input  in_valid, in_pixel,
    output out_valid, out_win, frame_done
  );
endinterface

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 sliding-window generator: two row shift buffers feed a 3x3
// window register; a window is flagged for every unpadded output position.
//
// state  | meaning
// S_FILL | rows 0..1 of the frame are being buffered, no windows emitted
// S_RUN  | row >= 2, a window is emitted for every accept with col >= 2
module window_gen_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 30,
  parameter int IMG_HEIGHT = 30
) (
  input  logic            clk,
  input  logic            reset,
  window_gen_3x3_if.slave bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_buf1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_buf2 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_win  [3][3];
  logic                  r_out_valid;
  logic                  r_frame_done;

  logic w_accept;
  logic w_col_last;
  logic w_frame_last;
  logic w_out_valid_nxt;
  logic w_frame_done_nxt;

  assign w_accept     = bus.in_valid;
  assign w_col_last   = (r_col == COL_LAST);
  assign w_frame_last = w_col_last && (r_row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (w_accept && w_col_last && (r_row == RW'(1))) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && w_frame_last) w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  // Columns 0 and 1 would straddle the previous row, so they are suppressed.
  always_comb begin
    w_out_valid_nxt  = 1'b0;
    w_frame_done_nxt = 1'b0;
    if (w_accept) begin
      w_out_valid_nxt  = (r_state == S_RUN) && (r_col >= CW'(2));
      w_frame_done_nxt = w_frame_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= w_out_valid_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Each buffer is exactly one row deep, so its tail is the pixel one row back.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < IMG_WIDTH; k++) begin
        r_buf1[k] <= '0;
        r_buf2[k] <= '0;
      end
    end else if (w_accept) begin
      r_buf1[0] <= bus.in_pixel;
      r_buf2[0] <= r_buf1[IMG_WIDTH-1];
      for (int k = 1; k < IMG_WIDTH; k++) begin
        r_buf1[k] <= r_buf1[k-1];
        r_buf2[k] <= r_buf2[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_win[i][j] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= r_win[i][2];
      end
      r_win[0][2] <= r_buf2[IMG_WIDTH-1];
      r_win[1][2] <= r_buf1[IMG_WIDTH-1];
      r_win[2][2] <= bus.in_pixel;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_col
      assign bus.out_win[DATA_WIDTH*(3*gi+gj) +: DATA_WIDTH] = r_win[gi][gj];
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3: a 4x4 instance for directed frames and a 30x30
// instance for a random frame, both checked every cycle against an image model.
module tb_window_gen_3x3;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  window_gen_3x3_if #(.DATA_WIDTH(DW)) if_s ();
  window_gen_3x3_if #(.DATA_WIDTH(DW)) if_l ();

  window_gen_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_s (
    .clk(clk), .reset(reset), .bus(if_s.slave)
  );
  window_gen_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(30), .IMG_HEIGHT(30)) dut_l (
    .clk(clk), .reset(reset), .bus(if_l.slave)
  );

  int          m_w [2] = '{4, 30};
  int          m_h [2] = '{4, 30};
  int          m_r [2];
  int          m_c [2];
  logic [7:0]  img [2][30][30];
  bit          exp_v [2];
  bit          exp_d [2];
  bit          exp_known [2];
  logic [71:0] exp_w [2];
  bit          armed;
  bit          chk_gap;
  bit          prev_v [2];
  int          win_cnt [2];
  int          done_cnt [2];
  logic [71:0] seen_s [$];
  int          total;
  int          bad;

  int lit_a [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
  int lit_b [9] = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
  int lit_c [9] = '{101, 102, 103, 105, 106, 107, 109, 110, 111};

  function automatic logic [71:0] pack9(input int a [9]);
    logic [71:0] v;
    for (int k = 0; k < 9; k++) v[8*k +: 8] = 8'(a[k]);
    return v;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Image model: remembers every accepted pixel at (row, col) and forms the
  // window straight from the image for the cycle after the accept.
  task automatic model(input int d, input bit v, input logic [7:0] pix, input bit rst);
    logic [71:0] w;
    if (rst) begin
      m_r[d] = 0; m_c[d] = 0;
      exp_v[d] = 0; exp_d[d] = 0; exp_w[d] = '0; exp_known[d] = 1;
    end else if (v) begin
      img[d][m_r[d]][m_c[d]] = pix;
      exp_d[d] = (m_r[d] == m_h[d] - 1) && (m_c[d] == m_w[d] - 1);
      if (m_r[d] >= 2 && m_c[d] >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w[8*(3*i+j) +: 8] = img[d][m_r[d]-2+i][m_c[d]-2+j];
        exp_v[d] = 1; exp_w[d] = w; exp_known[d] = 1;
      end else begin
        exp_v[d] = 0; exp_known[d] = 0;
      end
      m_c[d]++;
      if (m_c[d] == m_w[d]) begin
        m_c[d] = 0;
        m_r[d]++;
        if (m_r[d] == m_h[d]) m_r[d] = 0;
      end
    end else begin
      exp_v[d] = 0; exp_d[d] = 0;
    end
  endtask

  task automatic step(input int d, input bit v, input logic [7:0] pix, input bit rst);
    @(negedge clk);
    reset         = rst;
    if_s.in_valid = (d == 0) && v;
    if_s.in_pixel = pix;
    if_l.in_valid = (d == 1) && v;
    if_l.in_pixel = pix;
    for (int k = 0; k < 2; k++) model(k, (k == d) && v, pix, rst);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic pix_s(input int base, input bit toggle, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      step(0, 1'b1, 8'(base + i + 1), 1'b0);
      if (toggle) step(0, 1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic compare_loop();
    logic        ov [2];
    logic        od [2];
    logic [71:0] ow [2];
    forever begin
      @(posedge clk);
      #2;
      ov[0] = if_s.out_valid; od[0] = if_s.frame_done; ow[0] = if_s.out_win;
      ov[1] = if_l.out_valid; od[1] = if_l.frame_done; ow[1] = if_l.out_win;
      if (armed) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("out_valid[%0d]", k), 72'(ov[k]), 72'(exp_v[k]));
          chk($sformatf("frame_done[%0d]", k), 72'(od[k]), 72'(exp_d[k]));
          if (exp_known[k]) chk($sformatf("out_win[%0d]", k), ow[k], exp_w[k]);
          if (chk_gap && k == 0) chk("valid_gap", 72'(ov[k] && prev_v[k]), 72'(0));
          if (ov[k] === 1'b1) begin
            win_cnt[k]++;
            if (k == 0) seen_s.push_back(ow[k]);
          end
          if (od[k] === 1'b1) done_cnt[k]++;
          prev_v[k] = (ov[k] === 1'b1);
        end
      end
    end
  endtask

  initial begin
    int bw, bd, bi;
    reset = 1'b1;
    if_s.in_valid = 1'b0; if_s.in_pixel = '0;
    if_l.in_valid = 1'b0; if_l.in_pixel = '0;
    fork
      compare_loop();
    join_none

    step(0, 1'b0, 8'h00, 1'b1);
    armed = 1'b1;
    step(0, 1'b0, 8'h00, 1'b1);
    idle(2);

    // full 4x4 frame, continuous
    bw = win_cnt[0]; bd = done_cnt[0]; bi = seen_s.size();
    pix_s(0, 1'b0, 0, 15);
    idle(2);
    chk("t1_windows", 72'(win_cnt[0] - bw), 72'(4));
    chk("t1_done", 72'(done_cnt[0] - bd), 72'(1));
    chk("t1_first_win", seen_s[bi], pack9(lit_a));
    chk("t1_last_win", seen_s[bi+3], pack9(lit_b));

    // same frame with in_valid toggling every cycle
    bw = win_cnt[0]; bd = done_cnt[0]; bi = seen_s.size();
    chk_gap = 1'b1;
    pix_s(0, 1'b1, 0, 15);
    idle(2);
    chk_gap = 1'b0;
    chk("t2_windows", 72'(win_cnt[0] - bw), 72'(4));
    chk("t2_done", 72'(done_cnt[0] - bd), 72'(1));
    chk("t2_first_win", seen_s[bi], pack9(lit_a));
    chk("t2_last_win", seen_s[bi+3], pack9(lit_b));

    // two frames back-to-back with no bubble
    bw = win_cnt[0]; bd = done_cnt[0]; bi = seen_s.size();
    pix_s(0, 1'b0, 0, 15);
    pix_s(100, 1'b0, 0, 15);
    idle(2);
    chk("t3_windows", 72'(win_cnt[0] - bw), 72'(8));
    chk("t3_done", 72'(done_cnt[0] - bd), 72'(2));
    chk("t3_f2_first_win", seen_s[bi+4], pack9(lit_c));

    // reset mid-frame (with in_valid high) then a fresh frame
    bw = win_cnt[0];
    pix_s(0, 1'b0, 0, 6);
    step(0, 1'b1, 8'hAA, 1'b1);
    idle(1);
    chk("t4_partial_windows", 72'(win_cnt[0] - bw), 72'(0));
    bw = win_cnt[0]; bd = done_cnt[0]; bi = seen_s.size();
    pix_s(0, 1'b0, 0, 15);
    idle(2);
    chk("t4_windows", 72'(win_cnt[0] - bw), 72'(4));
    chk("t4_done", 72'(done_cnt[0] - bd), 72'(1));
    chk("t4_first_win", seen_s[bi], pack9(lit_a));

    // only rows 0 and 1, long idle, then resume
    bw = win_cnt[0]; bd = done_cnt[0]; bi = seen_s.size();
    pix_s(0, 1'b0, 0, 7);
    idle(20);
    chk("t6_idle_windows", 72'(win_cnt[0] - bw), 72'(0));
    chk("t6_idle_done", 72'(done_cnt[0] - bd), 72'(0));
    pix_s(0, 1'b0, 8, 15);
    idle(2);
    chk("t6_windows", 72'(win_cnt[0] - bw), 72'(4));
    chk("t6_first_win", seen_s[bi], pack9(lit_a));

    // 30x30 random frame with random stalls
    bw = win_cnt[1]; bd = done_cnt[1];
    for (int i = 0; i < 900; i++) begin
      idle(int'($urandom_range(0, 2)));
      step(1, 1'b1, 8'($urandom), 1'b0);
    end
    idle(3);
    chk("t5_windows", 72'(win_cnt[1] - bw), 72'(784));
    chk("t5_done", 72'(done_cnt[1] - bd), 72'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Streaming 3x3 sliding-window generator for the conv stage of the VGG16 datapath.
- Accepts one feature-map pixel per cycle in raster order and buffers two full rows internally as shift registers.
- Emits a full 3x3 window to the MAC array for every valid (unpadded) output position.
- Sits directly downstream of the pixel stream, packs buffered rows into windows, and feeds the convolution unit.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 30, pixels per row; must be >= 3.
- IMG_HEIGHT, 30, rows per frame; must be >= 3.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_pixel is accepted this cycle.
- in_pixel  in  DATA_WIDTH  input pixel, raster order.
- out_valid  out  1  out_win holds a new window; one-cycle pulse per window.
- out_win  out  9*DATA_WIDTH  window; slice [DATA_WIDTH*(3*i+j) +: DATA_WIDTH] = pixel(row r-2+i, col c-2+j).
- frame_done  out  1  one-cycle pulse; the last pixel of the frame was accepted.

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high: when reset=1 at a rising edge, the following all go to 0:
  - out_valid, frame_done, out_win;
  - row and col counters;
  - both row buffers;
  - the 3x3 window register.
- Reset takes priority over in_valid. Reset mid-frame abandons the frame; the next accepted pixel is (0,0).
- Row buffers: two chained shift registers, each IMG_WIDTH deep, advanced only on accept.
  - buf1 input = in_pixel; buf1 output = pixel one row above.
  - buf2 input = buf1 output; buf2 output = pixel two rows above.
- Window register: three columns of three pixels. On each accepted pixel:
  - columns shift left;
  - new right column = {buf2 out, buf1 out, in_pixel} for rows {top, mid, bottom}.
- Counters: col runs 0..IMG_WIDTH-1 and row runs 0..IMG_HEIGHT-1, both advanced on accept.
  - col wraps to 0 and row increments at col==IMG_WIDTH-1.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0.
- State machine:
  - FILL: row < 2. No windows are output.
  - RUN: row >= 2.
  - Transition FILL->RUN on the accept that moves row from 1 to 2.
  - Transition RUN->FILL on the accept of the last frame pixel.
- out_valid is registered: it is 1 in the cycle after accepting the pixel at (r,c) with r >= 2 and c >= 2, otherwise 0.
  - Latency is 1 cycle from accept to window.
  - Windows never straddle a row boundary: c = 0 and c = 1 are suppressed.
- out_win updates only on accept and holds its value while in_valid = 0. Its contents are don't-care when out_valid = 0.
- frame_done is registered: it is 1 in the cycle after accepting (IMG_HEIGHT-1, IMG_WIDTH-1), coincident with the final out_valid.
- Windows per frame = (IMG_HEIGHT-2)*(IMG_WIDTH-2).
- Stall: in_valid = 0 freezes buffers, counters, window and state; out_valid and frame_done are 0 on the next cycle. Stalls of any length are allowed anywhere in the frame.
- Back-to-back frames: no bubble is required. The first pixel of the next frame may arrive in the cycle after the last pixel of the previous frame. Stale buffer contents are harmless because out_valid is gated by the counters.
- No backpressure: the consumer must accept every out_valid pulse.
- No arithmetic on pixel data; values pass through bit-exact.

Test Plan:
1. IMG_WIDTH=4, IMG_HEIGHT=4, pixel(r,c)=4r+c+1, in_valid held 1 for 16 cycles:
   - exactly 4 out_valid pulses;
   - the first comes after pixel 11 is accepted, with out_win slices 0..8 = 1,2,3,5,6,7,9,10,11;
   - the last comes after pixel 16, with slices 0..8 = 6,7,8,10,11,12,14,15,16, coincident with frame_done.
2. Same stream as test 1 with in_valid toggled 1/0 every cycle:
   - same 4 windows in the same order;
   - out_valid never on two consecutive cycles;
   - out_win stable during stall cycles.
3. Two 4x4 frames back-to-back, second frame pixel = 100 + index:
   - 8 windows total;
   - the first window of frame 2 is 101,102,103,105,106,107,109,110,111;
   - frame_done pulses twice.
4. Reset asserted for 1 cycle after the 7th pixel of a 4x4 frame, then a full fresh frame:
   - out_valid is 0 during and after reset until the fresh frame's pixel 11;
   - then the same 4 windows as test 1;
   - all outputs are 0 in the cycle after reset.
5. Default params, 900 random pixels, random stalls:
   - 784 windows, each matching the reference model's window at its position;
   - one frame_done pulse.
6. 4x4 frame with in_valid=1 only on row 0 and row 1 pixels, then idle for 20 cycles:
   - no out_valid and no frame_done;
   - resuming row 2 produces the first window at pixel (2,2).
